// File: rtl/uart_cmd_decoder_fifo.sv
// ASCII command decoder: parses <cmd><hex digits><terminator> frames from a byte stream
// into {cmd, data} words held in a show-ahead FIFO drained by valid/ready.
module uart_cmd_decoder_fifo #(
   parameter int DATA_W      = 32,
   parameter int FIFO_DEPTH  = 4,
   parameter bit ALLOW_EMPTY = 1'b1
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [7:0]                    i_data,
   input  logic                          i_data_valid,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [DATA_W+1:0]             o_word,
   output logic [$clog2(FIFO_DEPTH):0]   o_level,
   output logic                          o_err,
   output logic [1:0]                    o_err_code,
   output logic                          o_drop
);

   localparam int MAX_DIGITS = DATA_W / 4;
   localparam int CW         = $clog2(MAX_DIGITS + 1);
   localparam int AW         = $clog2(FIFO_DEPTH);
   localparam int LW         = AW + 1;
   localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_DIGITS);
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_COLLECT = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [1:0]            r_cmd;
   logic [DATA_W-1:0]     r_acc;
   logic [CW-1:0]         r_cnt;
   logic [1:0]            w_cmd_nxt;
   logic [DATA_W-1:0]     w_acc_nxt;
   logic [CW-1:0]         w_cnt_nxt;

   logic [7:0]            w_byte;
   logic                  w_is_cmd;
   logic                  w_is_hex;
   logic                  w_is_term;
   logic [1:0]            w_cmd_val;
   logic [3:0]            w_nib;

   logic                  w_emit;
   logic                  w_empty_err;
   logic                  w_parse_err;
   logic [1:0]            w_parse_code;
   logic                  w_err_any;
   logic [1:0]            w_err_code;
   logic                  w_push_req;
   logic [DATA_W+1:0]     w_push_word;

   logic                  r_err;
   logic [1:0]            r_err_code;
   logic                  r_drop;

   logic [DATA_W+1:0]     r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [LW-1:0]         r_level;
   logic [DATA_W+1:0]     r_last;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_push_ok;
   logic                  w_drop;

   // Bit 7 is masked off so every byte is classified as 7-bit ASCII.
   assign w_byte = i_data & 8'h7F;

   always_comb begin
      w_is_cmd  = 1'b0;
      w_is_hex  = 1'b0;
      w_is_term = 1'b0;
      w_cmd_val = 2'd0;
      w_nib     = 4'd0;
      case (w_byte)
         8'h52:               begin w_is_cmd = 1'b1; w_cmd_val = 2'd0; end
         8'h57:               begin w_is_cmd = 1'b1; w_cmd_val = 2'd1; end
         8'h41:               begin w_is_cmd = 1'b1; w_cmd_val = 2'd2; end
         8'h53:               begin w_is_cmd = 1'b1; w_cmd_val = 2'd3; end
         8'h45, 8'h0A, 8'h0D: w_is_term = 1'b1;
         default:             ;
      endcase
      if (w_byte >= 8'h30 && w_byte <= 8'h39) begin
         w_is_hex = 1'b1;
         w_nib    = w_byte[3:0];
      end else if (w_byte >= 8'h61 && w_byte <= 8'h66) begin
         w_is_hex = 1'b1;
         w_nib    = w_byte[3:0] + 4'd9;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_data_valid) begin
         case (r_state)
            S_IDLE: begin
               if (w_is_cmd) w_state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
               if (w_is_hex) begin
                  if (r_cnt == MAX_CNT) w_state_nxt = S_IDLE;
               end else if (w_is_term) begin
                  w_state_nxt = S_IDLE;
               end else if (!w_is_cmd) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_cmd_nxt    = r_cmd;
      w_acc_nxt    = r_acc;
      w_cnt_nxt    = r_cnt;
      w_emit       = 1'b0;
      w_parse_err  = 1'b0;
      w_parse_code = 2'd0;
      if (i_data_valid) begin
         case (r_state)
            S_IDLE: begin
               if (w_is_cmd) begin
                  w_cmd_nxt = w_cmd_val;
                  w_acc_nxt = '0;
                  w_cnt_nxt = '0;
               end else if (w_is_hex) begin
                  w_parse_err  = 1'b1;
                  w_parse_code = 2'd0;
               end
            end
            S_COLLECT: begin
               if (w_is_hex) begin
                  if (r_cnt == MAX_CNT) begin
                     w_parse_err  = 1'b1;
                     w_parse_code = 2'd1;
                  end else begin
                     w_acc_nxt = DATA_W'({r_acc, w_nib});
                     w_cnt_nxt = r_cnt + 1'b1;
                  end
               end else if (w_is_term) begin
                  w_emit = 1'b1;
               end else if (w_is_cmd) begin
                  // The pending frame is flushed before the new command takes over.
                  w_emit    = 1'b1;
                  w_cmd_nxt = w_cmd_val;
                  w_acc_nxt = '0;
                  w_cnt_nxt = '0;
               end else begin
                  w_parse_err  = 1'b1;
                  w_parse_code = 2'd2;
               end
            end
            default: ;
         endcase
      end
      w_empty_err = w_emit && (r_cnt == '0) && !ALLOW_EMPTY;
      w_push_req  = w_emit && !w_empty_err;
      w_push_word = {r_cmd, r_acc};
      w_err_any   = w_parse_err || w_empty_err;
      w_err_code  = w_empty_err ? 2'd3 : w_parse_code;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cmd      <= 2'd0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_err      <= 1'b0;
         r_err_code <= 2'd0;
         r_drop     <= 1'b0;
      end else begin
         r_cmd  <= w_cmd_nxt;
         r_acc  <= w_acc_nxt;
         r_cnt  <= w_cnt_nxt;
         r_err  <= w_err_any;
         r_drop <= w_drop;
         if (w_err_any) r_err_code <= w_err_code;
      end
   end

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_pop     = o_valid && i_ready;
   assign w_full    = (r_level == FULL_LVL);
   assign w_push_ok = w_push_req && (!w_full || w_pop);
   assign w_drop    = w_push_req && w_full && !w_pop;

   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= w_push_word;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_last   <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_last   <= r_mem[r_rd_ptr];
         end
         case ({w_push_ok, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_valid    = (r_level != '0);
   assign o_level    = r_level;
   assign o_word     = o_valid ? r_mem[r_rd_ptr] : r_last;
   assign o_err      = r_err;
   assign o_err_code = r_err_code;
   assign o_drop     = r_drop;

endmodule

// File: tb/tb_uart_cmd_decoder_fifo.sv
// Bench for uart_cmd_decoder_fifo: two instances (empty frames allowed / rejected) checked
// every cycle against a frame-level model, plus literal expectations for the directed cases.
module tb_uart_cmd_decoder_fifo;

   localparam int W    = 32;
   localparam int D    = 4;
   localparam int LW   = 3;
   localparam int WW   = W + 2;
   localparam int MAXD = W / 4;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    din   = 8'h00;
   logic          dv    = 1'b0;
   logic          rdy   = 1'b0;

   logic          a_valid, b_valid;
   logic [WW-1:0] a_word,  b_word;
   logic [LW-1:0] a_level, b_level;
   logic          a_err,   b_err;
   logic [1:0]    a_code,  b_code;
   logic          a_drop,  b_drop;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   uart_cmd_decoder_fifo #(.DATA_W(W), .FIFO_DEPTH(D), .ALLOW_EMPTY(1'b1)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_data_valid(dv),
      .o_valid(a_valid), .i_ready(rdy), .o_word(a_word), .o_level(a_level),
      .o_err(a_err), .o_err_code(a_code), .o_drop(a_drop));

   uart_cmd_decoder_fifo #(.DATA_W(W), .FIFO_DEPTH(D), .ALLOW_EMPTY(1'b0)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_data_valid(dv),
      .o_valid(b_valid), .i_ready(rdy), .o_word(b_word), .o_level(b_level),
      .o_err(b_err), .o_err_code(b_code), .o_drop(b_drop));

   // Model state, index 0 = empty frames allowed, 1 = rejected
   bit            m_in   [2];
   logic [1:0]    m_cmd  [2];
   logic [63:0]   m_val  [2];
   int            m_n    [2];
   logic [WW-1:0] m_q    [2][D];
   int            m_sz   [2];
   bit            e_err  [2];
   logic [1:0]    e_code [2];
   bit            e_drop [2];

   // 0 = command, 1 = hex digit, 2 = terminator, 3 = other
   function automatic int char_kind(input logic [6:0] c);
      if (c == "R" || c == "W" || c == "A" || c == "S") return 0;
      if ((c >= "0" && c <= "9") || (c >= "a" && c <= "f")) return 1;
      if (c == "E" || c == 7'h0A || c == 7'h0D) return 2;
      return 3;
   endfunction

   function automatic logic [1:0] cmd_code(input logic [6:0] c);
      if (c == "R") return 2'd0;
      if (c == "W") return 2'd1;
      if (c == "A") return 2'd2;
      return 2'd3;
   endfunction

   function automatic int nibble(input logic [6:0] c);
      if (c >= "a") return int'(c) - int'("a") + 10;
      return int'(c) - int'("0");
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_in[k] = 0; m_cmd[k] = 2'd0; m_val[k] = '0; m_n[k] = 0; m_sz[k] = 0;
         e_err[k] = 0; e_code[k] = 2'd0; e_drop[k] = 0;
      end
   endtask

   task automatic model_emit(input int k, output bit push, output logic [WW-1:0] pw);
      push = 0;
      pw   = '0;
      if (m_n[k] == 0 && k == 1) begin
         e_err[k] = 1; e_code[k] = 2'd3;
      end else begin
         push = 1;
         pw   = {m_cmd[k], m_val[k][W-1:0]};
      end
   endtask

   task automatic model_step(input int k, input bit v, input logic [7:0] d, input bit r);
      bit            pop, push, acc;
      logic [WW-1:0] pw;
      logic [6:0]    c;
      int            kind;
      e_err[k]  = 0;
      e_drop[k] = 0;
      push      = 0;
      pw        = '0;
      pop       = (m_sz[k] > 0) && r;
      if (v) begin
         c    = d[6:0];
         kind = char_kind(c);
         if (!m_in[k]) begin
            if (kind == 0) begin
               m_in[k] = 1; m_cmd[k] = cmd_code(c); m_val[k] = 0; m_n[k] = 0;
            end else if (kind == 1) begin
               e_err[k] = 1; e_code[k] = 2'd0;
            end
         end else begin
            case (kind)
               1: begin
                  if (m_n[k] < MAXD) begin
                     m_val[k] = m_val[k] * 16 + 64'(nibble(c));
                     m_n[k]   = m_n[k] + 1;
                  end else begin
                     e_err[k] = 1; e_code[k] = 2'd1; m_in[k] = 0;
                  end
               end
               2: begin
                  model_emit(k, push, pw);
                  m_in[k] = 0;
               end
               0: begin
                  model_emit(k, push, pw);
                  m_cmd[k] = cmd_code(c); m_val[k] = 0; m_n[k] = 0;
               end
               default: begin
                  e_err[k] = 1; e_code[k] = 2'd2; m_in[k] = 0;
               end
            endcase
         end
      end
      acc = push && (m_sz[k] < D || pop);
      if (push && !acc) e_drop[k] = 1;
      if (pop) begin
         for (int i = 0; i < D - 1; i++) m_q[k][i] = m_q[k][i+1];
         m_sz[k] = m_sz[k] - 1;
      end
      if (acc) begin
         m_q[k][m_sz[k]] = pw;
         m_sz[k] = m_sz[k] + 1;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else begin
         model_step(0, dv, din, rdy);
         model_step(1, dv, din, rdy);
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic check_inst(input int k, input string p, input logic v, input logic [LW-1:0] lv,
                             input logic [WW-1:0] w, input logic er, input logic [1:0] cd,
                             input logic dr);
      check({p, ".valid"}, 64'(v), 64'(m_sz[k] > 0));
      check({p, ".level"}, 64'(lv), 64'(m_sz[k]));
      check({p, ".err"}, 64'(er), 64'(e_err[k]));
      check({p, ".drop"}, 64'(dr), 64'(e_drop[k]));
      if (e_err[k]) check({p, ".err_code"}, 64'(cd), 64'(e_code[k]));
      if (m_sz[k] > 0) check({p, ".word"}, 64'(w), 64'(m_q[k][0]));
   endtask

   always @(negedge clk) begin
      check_inst(0, "a", a_valid, a_level, a_word, a_err, a_code, a_drop);
      check_inst(1, "b", b_valid, b_level, b_word, b_err, b_code, b_drop);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      din = b;
      dv  = 1'b1;
      tick();
      dv  = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic drain();
      rdy = 1'b1;
      repeat (D + 2) tick();
      rdy = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (2) tick();
      check("reset.valid", 64'(a_valid), 64'd0);
      check("reset.level", 64'(a_level), 64'd0);
      check("reset.err", 64'(a_err), 64'd0);
      check("reset.code", 64'(a_code), 64'd0);
      check("reset.drop", 64'(a_drop), 64'd0);
      check("reset.word", 64'(a_word), 64'd0);
      rst_n = 1'b1;
      tick();

      // Single frame with 4 digits
      send_str("A1234E");
      check("t1.valid", 64'(a_valid), 64'd1);
      check("t1.level", 64'(a_level), 64'd1);
      check("t1.word", 64'(a_word), 64'h2_0000_1234);
      check("t1.model_word", 64'(m_q[0][0]), 64'h2_0000_1234);
      check("t1.err", 64'(a_err), 64'd0);
      drain();

      // Back-to-back command flushes the pending frame
      rdy = 1'b1;
      send_str("W12");
      send_byte("R");
      check("t2.word1", 64'(a_word), 64'h1_0000_0012);
      send_str("5\n");
      check("t2.word2", 64'(a_word), 64'h0_0000_0005);
      drain();

      // Overlong payload, then a normal frame
      send_str("W12345678");
      send_byte("9");
      check("t3.err", 64'(a_err), 64'd1);
      check("t3.code", 64'(a_code), 64'd1);
      send_byte("E");
      check("t3.level", 64'(a_level), 64'd0);
      send_str("R7E");
      check("t3.word", 64'(a_word), 64'h0_0000_0007);
      drain();

      // Orphan digit, bad character, empty frame
      send_byte("5");
      check("t4.orphan_code", 64'(a_code), 64'd0);
      check("t4.orphan_err", 64'(a_err), 64'd1);
      send_str("A1 ");
      check("t4.bad_code", 64'(a_code), 64'd2);
      send_byte("2");
      check("t4.orphan2_code", 64'(a_code), 64'd0);
      send_byte("E");
      check("t4.after_e_err", 64'(a_err), 64'd0);
      check("t4.after_e_level", 64'(a_level), 64'd0);
      send_str("RE");
      check("t4.a_valid", 64'(a_valid), 64'd1);
      check("t4.a_word", 64'(a_word), 64'd0);
      check("t4.b_err", 64'(b_err), 64'd1);
      check("t4.b_code", 64'(b_code), 64'd3);
      check("t4.b_level", 64'(b_level), 64'd0);
      drain();

      // Overflow: fifth frame is dropped, head unchanged
      rdy = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         send_byte("R");
         send_byte(8'("0") + 8'(i));
         send_byte("E");
      end
      check("t5.level", 64'(a_level), 64'd4);
      check("t5.drop", 64'(a_drop), 64'd1);
      check("t5.head", 64'(a_word), 64'h0_0000_0001);
      check("t5.model_size", 64'(m_sz[0]), 64'd4);
      send_str("W6");
      din = "E";
      dv  = 1'b1;
      rdy = 1'b1;
      tick();
      dv  = 1'b0;
      rdy = 1'b0;
      check("t5.swap_level", 64'(a_level), 64'd4);
      check("t5.swap_drop", 64'(a_drop), 64'd0);
      check("t5.swap_head", 64'(a_word), 64'h0_0000_0002);
      drain();

      // Asynchronous reset mid-frame
      send_str("R1E");
      send_str("W2E");
      send_str("A3");
      check("t6.pre_level", 64'(a_level), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6.rst_valid", 64'(a_valid), 64'd0);
      check("t6.rst_level", 64'(a_level), 64'd0);
      check("t6.rst_b_level", 64'(b_level), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      send_str("S0fE");
      check("t6.word", 64'(a_word), 64'h3_0000_000f);
      check("t6.level", 64'(a_level), 64'd1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/uart_cmd_decoder_fifo.md
Name: uart_cmd_decoder_fifo

Overview:
Parametrised ASCII command decoder for the UART-to-Wishbone bridge. It takes one received byte per strobe and parses frames of the form <cmd><hex digits><terminator>. Each complete frame becomes a {cmd, data} word in a show-ahead FIFO, which the bus master drains with a valid/ready handshake. Malformed input raises an error pulse with a code, and frames that arrive when the FIFO is full are dropped and flagged.

Parameters:
DATA_W, 32, payload width in bits; a multiple of 4 in the range 4..64. MAX_DIGITS = DATA_W/4.
FIFO_DEPTH, 4, number of decoded-word entries; a power of 2, at least 2.
ALLOW_EMPTY, 1, 1 = a command with zero digits is emitted with data 0; 0 = such a frame is an error.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_data  in  8  received byte; bit 7 is ignored
i_data_valid  in  1  one-cycle strobe, one byte per strobe
o_valid  out  1  FIFO head valid
i_ready  in  1  consumer accepts the head word
o_word  out  DATA_W+2  {cmd[1:0], data[DATA_W-1:0]} at the FIFO head
o_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
o_err  out  1  one-cycle parse-error pulse
o_err_code  out  2  error code, valid while o_err=1
o_drop  out  1  one-cycle pulse: a completed frame was lost because the FIFO was full

Behaviour:
- Async reset: o_valid=0, o_level=0, o_err=0, o_err_code=0, o_drop=0, o_word=0. FIFO pointers cleared, parser in IDLE, accumulator and digit count cleared. A reset mid-frame discards the partial frame and all FIFO contents.
- Character classes (on i_data[6:0]):
  - CMD: 'R'(0x52)->0, 'W'(0x57)->1, 'A'(0x41)->2, 'S'(0x53)->3.
  - HEX: '0'-'9', 'a'-'f' only. Uppercase hex is not accepted, to avoid collision with 'A' and 'E'.
  - TERM: 'E'(0x45), LF(0x0A), CR(0x0D).
  - OTHER: everything else.
- Bytes are processed only in cycles where i_data_valid=1. Other cycles leave parser state unchanged.
- State IDLE:
  - CMD -> latch cmd, acc=0, cnt=0, go to COLLECT.
  - HEX -> o_err, code 0 (orphan digit); stay in IDLE.
  - TERM or OTHER -> silently ignored.
- State COLLECT:
  - HEX with cnt<MAX_DIGITS -> acc={acc[DATA_W-5:0], nibble}, cnt++.
  - HEX with cnt==MAX_DIGITS -> o_err, code 1 (overlong); frame discarded; go to IDLE.
  - TERM -> emit the frame; go to IDLE.
  - CMD -> emit the pending frame, then start a new frame with the new cmd (acc=0, cnt=0); stay in COLLECT.
  - OTHER -> o_err, code 2 (bad char); frame discarded; go to IDLE.
- Emit rule:
  - If cnt==0 and ALLOW_EMPTY=0 -> o_err, code 3 (empty); no push.
  - Otherwise push {cmd, acc}. Data is right-aligned and zero-extended, so fewer than MAX_DIGITS digits give leading zeros.
- Error and drop pulses assert in the cycle after the offending byte and last exactly 1 cycle.
- FIFO:
  - Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped, o_drop pulses, and FIFO contents are unchanged.
  - Pop occurs when o_valid && i_ready. i_ready while empty has no effect.
  - Simultaneous push and pop on an empty FIFO is not possible, because the head is not yet valid. The push lands and o_valid rises.
  - Pointers wrap modulo FIFO_DEPTH. o_level is exact: 0..FIFO_DEPTH.
- Latency: a terminator byte at cycle N gives o_valid=1 with that word at cycle N+1, provided the FIFO was empty.
- o_word is show-ahead, stable while o_valid=1 and i_ready=0.
- o_word holds its last value when empty; consumers must not rely on it.

Test Plan:
- DATA_W=32. Bytes "A1234E" -> one word {2'b10, 32'h00001234}; o_valid rises 1 cycle after 'E'; o_level=1; no o_err.
- Bytes "W12R5\n" with i_ready=1 -> two words in order: {01, 32'h12}, then {00, 32'h5}. A back-to-back command flushes the pending frame.
- Bytes "W123456789E" (9 digits) -> o_err with code 1 on the 9th digit; nothing pushed. The following "R7E" decodes normally.
- Bytes "5", "A1 2E", then "RE":
  - "5" -> o_err code 0.
  - "A1 2E" -> o_err code 2 at the space; the remaining '2' gives code 0; 'E' is ignored.
  - "RE" with ALLOW_EMPTY=0 -> code 3. With ALLOW_EMPTY=1 -> word {00, 0}.
- FIFO_DEPTH=4, i_ready=0, send 5 frames -> o_level=4, one o_drop pulse, and the head is still the first word.
  - Then assert i_ready together with a 6th frame's terminator -> pop and push in the same cycle, o_level stays 4, no o_drop.
- Assert i_rst_n=0 asynchronously mid-frame with o_level=2 -> o_valid=0 and o_level=0 immediately. After release, "S0fE" gives {11, 32'hf}.
